obi_sb_arbiter: RTL and testbench



---
 rtl/obi_sb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_obi_sb_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/obi_sb_arbiter.sv
// -----------------------------------------------------------------------------
// obi_sb_arbiter
//
// Shares one 32-bit OBI system bus between two initiators: the CPU data port
// (initiator 0) and the debug module's system-bus-access master (initiator 1).
// Round-robin arbitration. An address phase that has been issued but not yet
// granted is held (locked) so that the request stays stable, as OBI requires.
// The initiator ID of every granted transaction is queued in a small FIFO, so
// each response is returned to the initiator that issued it. The request,
// grant and response paths are purely combinational (no added latency).
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mX_req_i / mX_gnt_o          initiator X request / grant (X = 0, 1)
//   mX_we_i, mX_addr_i,
//   mX_be_i, mX_wdata_i          initiator X address phase
//   mX_rdata_o, mX_rvalid_o      initiator X response
//   s_req_o / s_gnt_i            request / grant to the interconnect
//   s_we_o, s_addr_o,
//   s_be_o, s_wdata_o            muxed address phase
//   s_rvalid_i, s_rdata_i        response from the interconnect
//   err_o                        sticky: response arrived with nothing in flight
// -----------------------------------------------------------------------------
module obi_sb_arbiter #(
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned AddrWidth      = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   input  logic                 m0_req_i,
   output logic                 m0_gnt_o,
   input  logic                 m0_we_i,
   input  logic [AddrWidth-1:0] m0_addr_i,
   input  logic [3:0]           m0_be_i,
   input  logic [31:0]          m0_wdata_i,
   output logic [31:0]          m0_rdata_o,
   output logic                 m0_rvalid_o,

   input  logic                 m1_req_i,
   output logic                 m1_gnt_o,
   input  logic                 m1_we_i,
   input  logic [AddrWidth-1:0] m1_addr_i,
   input  logic [3:0]           m1_be_i,
   input  logic [31:0]          m1_wdata_i,
   output logic [31:0]          m1_rdata_o,
   output logic                 m1_rvalid_o,

   output logic                 s_req_o,
   input  logic                 s_gnt_i,
   output logic                 s_we_o,
   output logic [AddrWidth-1:0] s_addr_o,
   output logic [3:0]           s_be_o,
   output logic [31:0]          s_wdata_o,
   input  logic                 s_rvalid_i,
   input  logic [31:0]          s_rdata_i,

   output logic                 err_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

   // Registered state
   logic                      sel_reg;
   logic                      locked_reg;
   logic                      last_reg;
   logic                      err_reg;
   logic [MaxOutstanding-1:0] id_mem_reg;
   logic [PtrW-1:0]           wr_ptr_reg;
   logic [PtrW-1:0]           rd_ptr_reg;
   logic [CntW-1:0]           count_reg;

   // Combinational decisions
   logic chosen;
   logic chosen_req;
   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic head_id;

   // Pointer wrap that also works for depths that are not a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + 1'b1;
   endfunction

   // Arbitration: a locked selection wins outright; otherwise a lone
   // requester wins, and on a tie the initiator not granted last wins.
   always_comb begin
      chosen = ~last_reg;
      if (locked_reg) begin
         chosen = sel_reg;
      end else if (m0_req_i && !m1_req_i) begin
         chosen = 1'b0;
      end else if (m1_req_i && !m0_req_i) begin
         chosen = 1'b1;
      end
   end

   assign fifo_full  = (count_reg == CntMax);
   assign fifo_empty = (count_reg == '0);
   assign chosen_req = chosen ? m1_req_i : m0_req_i;

   // Full blocks issue even if a pop frees a slot this same cycle; this keeps
   // s_req_o independent of s_rvalid_i.
   assign s_req_o   = chosen_req && !fifo_full;
   assign s_we_o    = chosen ? m1_we_i    : m0_we_i;
   assign s_addr_o  = chosen ? m1_addr_i  : m0_addr_i;
   assign s_be_o    = chosen ? m1_be_i    : m0_be_i;
   assign s_wdata_o = chosen ? m1_wdata_i : m0_wdata_i;

   assign push     = s_req_o && s_gnt_i;
   assign m0_gnt_o = push && !chosen;
   assign m1_gnt_o = push &&  chosen;

   // Response routing: the FIFO head names the initiator that owns it.
   assign head_id     = id_mem_reg[rd_ptr_reg];
   assign pop         = s_rvalid_i && !fifo_empty;
   assign m0_rvalid_o = pop && !head_id;
   assign m1_rvalid_o = pop &&  head_id;
   assign m0_rdata_o  = s_rdata_i;
   assign m1_rdata_o  = s_rdata_i;
   assign err_o       = err_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sel_reg    <= 1'b0;
         locked_reg <= 1'b0;
         last_reg   <= 1'b1;
         err_reg    <= 1'b0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         // Lock is only touched while a request is actually presented, so a
         // held selection survives a full FIFO.
         if (s_req_o && !s_gnt_i) begin
            locked_reg <= 1'b1;
            sel_reg    <= chosen;
         end else if (push) begin
            locked_reg <= 1'b0;
         end

         if (push) begin
            last_reg               <= chosen;
            id_mem_reg[wr_ptr_reg] <= chosen;
            wr_ptr_reg             <= ptr_inc(wr_ptr_reg);
         end

         if (pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase

         if (s_rvalid_i && fifo_empty) begin
            err_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_obi_sb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_obi_sb_arbiter
//
// Directed, table-driven bench for obi_sb_arbiter (MaxOutstanding = 2).
// Each table row drives one clock cycle of inputs and lists the outputs
// expected in that cycle before the clock edge. A short hand-written sequence
// afterwards covers sustained alternating throughput with overlapping
// responses.
// -----------------------------------------------------------------------------
module tb_obi_sb_arbiter;

   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h2000_0000;
   localparam logic [31:0] D0 = 32'hA0A0_A0A0;
   localparam logic [31:0] D1 = 32'hB1B1_B1B1;
   localparam logic [3:0]  B0 = 4'hF;
   localparam logic [3:0]  B1 = 4'h3;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m1_req, m0_gnt, m1_gnt;
   logic        m0_we, m1_we;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_rvalid, m1_rvalid;
   logic        s_req, s_gnt, s_we, s_rvalid, err;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_be;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   obi_sb_arbiter #(.MaxOutstanding(2), .AddrWidth(32)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .m0_req_i   (m0_req),
      .m0_gnt_o   (m0_gnt),
      .m0_we_i    (m0_we),
      .m0_addr_i  (m0_addr),
      .m0_be_i    (m0_be),
      .m0_wdata_i (m0_wdata),
      .m0_rdata_o (m0_rdata),
      .m0_rvalid_o(m0_rvalid),
      .m1_req_i   (m1_req),
      .m1_gnt_o   (m1_gnt),
      .m1_we_i    (m1_we),
      .m1_addr_i  (m1_addr),
      .m1_be_i    (m1_be),
      .m1_wdata_i (m1_wdata),
      .m1_rdata_o (m1_rdata),
      .m1_rvalid_o(m1_rvalid),
      .s_req_o    (s_req),
      .s_gnt_i    (s_gnt),
      .s_we_o     (s_we),
      .s_addr_o   (s_addr),
      .s_be_o     (s_be),
      .s_wdata_o  (s_wdata),
      .s_rvalid_i (s_rvalid),
      .s_rdata_i  (s_rdata),
      .err_o      (err)
   );

   typedef struct {
      logic        rst, r0, r1, gnt, rv;
      logic [31:0] rdata;
      logic        esreq, eg0, eg1, ev0, ev1;
      logic        chk_sel;   // compare the muxed address phase this row
      logic        esel;      // initiator whose address phase must appear
      logic        eerr;
   } vec_t;

   vec_t vec[$];

   function automatic vec_t mk(
      input logic rst_v, r0, r1, gnt, rv, input logic [31:0] rdata,
      input logic esreq, eg0, eg1, ev0, ev1, chk_sel, esel, eerr);
      vec_t v;
      v.rst = rst_v; v.r0 = r0; v.r1 = r1; v.gnt = gnt; v.rv = rv;
      v.rdata = rdata;
      v.esreq = esreq; v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1;
      v.chk_sel = chk_sel; v.esel = esel; v.eerr = eerr;
      return v;
   endfunction

   task automatic chk(input string name, input int row,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic rst_v, r0, r1, gnt, rv, input logic [31:0] rdata);
      rst = rst_v; m0_req = r0; m1_req = r1; s_gnt = gnt;
      s_rvalid = rv; s_rdata = rdata;
   endtask

   task automatic check_row(input int row, input vec_t v);
      chk("s_req",     row, {31'd0, s_req},     {31'd0, v.esreq});
      chk("m0_gnt",    row, {31'd0, m0_gnt},    {31'd0, v.eg0});
      chk("m1_gnt",    row, {31'd0, m1_gnt},    {31'd0, v.eg1});
      chk("m0_rvalid", row, {31'd0, m0_rvalid}, {31'd0, v.ev0});
      chk("m1_rvalid", row, {31'd0, m1_rvalid}, {31'd0, v.ev1});
      chk("err",       row, {31'd0, err},       {31'd0, v.eerr});
      chk("m0_rdata",  row, m0_rdata, v.rdata);
      chk("m1_rdata",  row, m1_rdata, v.rdata);
      if (v.chk_sel) begin
         chk("s_addr",  row, s_addr,  v.esel ? A1 : A0);
         chk("s_wdata", row, s_wdata, v.esel ? D1 : D0);
         chk("s_be",    row, {28'd0, s_be}, {28'd0, (v.esel ? B1 : B0)});
         chk("s_we",    row, {31'd0, s_we}, {31'd0, ~v.esel});
      end
   endtask

   initial begin
      m0_we = 1'b1; m0_addr = A0; m0_be = B0; m0_wdata = D0;
      m1_we = 1'b0; m1_addr = A1; m1_be = B1; m1_wdata = D1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      //              rst r0 r1 gnt rv rdata          sreq g0 g1 v0 v1 chk sel err
      // reset state
      vec.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 0));
      // tie after reset: m0, m1, m0, m1; responses overlap and follow FIFO order
      vec.push_back(mk(0, 1, 1, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 0, 0));
      vec.push_back(mk(0, 1, 1, 1, 1, 32'h0000_0011,  1, 0, 1, 1, 0, 1, 1, 0));
      vec.push_back(mk(0, 1, 1, 1, 1, 32'h0000_0022,  1, 1, 0, 0, 1, 1, 0, 0));
      vec.push_back(mk(0, 1, 1, 1, 1, 32'h0000_0033,  1, 0, 1, 1, 0, 1, 1, 0));
      vec.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0044,  0, 0, 0, 0, 1, 0, 0, 0));
      // lock: m1 held ungranted for 3 cycles, m0 joins, then grant
      vec.push_back(mk(0, 0, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 1, 1, 0));
      vec.push_back(mk(0, 1, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 1, 1, 0));
      vec.push_back(mk(0, 1, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 1, 1, 0));
      vec.push_back(mk(0, 1, 1, 1, 0, 32'h0,          1, 0, 1, 0, 0, 1, 1, 0));
      vec.push_back(mk(0, 1, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 0, 0));
      // full (ids 1,0 in flight): no issue, not even in the pop cycle
      vec.push_back(mk(0, 1, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 0, 0));
      vec.push_back(mk(0, 1, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 0, 0));
      vec.push_back(mk(0, 1, 0, 1, 1, 32'hDEAD_BEEF,  0, 0, 0, 0, 1, 1, 0, 0));
      // reissue after the pop, together with the second response (push+pop)
      vec.push_back(mk(0, 1, 0, 1, 1, 32'h1234_5678,  1, 1, 0, 1, 0, 1, 0, 0));
      // push+pop with count 1: old head (m0) answered, new id m1 queued
      vec.push_back(mk(0, 0, 1, 1, 1, 32'h0000_0055,  1, 0, 1, 1, 0, 1, 1, 0));
      vec.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0066,  0, 0, 0, 0, 1, 0, 0, 0));
      // full with m0 granted twice
      vec.push_back(mk(0, 1, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 0, 0));
      vec.push_back(mk(0, 1, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 0, 0));
      vec.push_back(mk(0, 1, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 1, 0, 0));
      vec.push_back(mk(0, 1, 0, 1, 1, 32'h0000_0077,  0, 0, 0, 1, 0, 1, 0, 0));
      vec.push_back(mk(0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 1, 0, 0));
      vec.push_back(mk(0, 1, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 0, 0));
      vec.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0088,  0, 0, 0, 1, 0, 0, 0, 0));
      vec.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0099,  0, 0, 0, 1, 0, 0, 0, 0));
      // unexpected response: sticky error, no rvalid, cleared by reset
      vec.push_back(mk(0, 0, 0, 0, 1, 32'h0000_00AA,  0, 0, 0, 0, 0, 0, 0, 0));
      vec.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(0, 0, 0, 0, 1, 32'h0000_00BB,  0, 0, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 1));
      vec.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 0));
      // during reset s_req follows inputs; reset must not leave a lock behind
      vec.push_back(mk(1, 0, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 1, 1, 0));
      vec.push_back(mk(0, 1, 1, 1, 0, 32'h0,          1, 1, 0, 0, 0, 1, 0, 0));
      vec.push_back(mk(0, 0, 0, 0, 1, 32'h0000_00CC,  0, 0, 0, 1, 0, 0, 0, 0));

      @(posedge clk); #1;
      for (int i = 0; i < vec.size(); i++) begin
         drive(vec[i].rst, vec[i].r0, vec[i].r1, vec[i].gnt, vec[i].rv, vec[i].rdata);
         @(negedge clk);
         $display("row %0d: rst=%0b req=%0b%0b gnt=%0b rv=%0b -> s_req=%0b g=%0b%0b v=%0b%0b addr=%h err=%0b",
                  i, rst, m1_req, m0_req, s_gnt, s_rvalid, s_req, m1_gnt, m0_gnt,
                  m1_rvalid, m0_rvalid, s_addr, err);
         check_row(i, vec[i]);
         @(posedge clk); #1;
      end

      // Sustained ties with a response every cycle after the first grant:
      // grants must alternate m0/m1 and responses follow one cycle behind.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      for (int i = 0; i < 7; i++) begin
         logic req_on;
         logic exp_g1;
         logic exp_v1;
         logic exp_rv;
         req_on = (i < 6);
         exp_g1 = (i % 2) == 1;
         exp_rv = (i > 0);
         exp_v1 = ((i - 1) % 2) == 1;
         drive(1'b0, req_on, req_on, req_on, exp_rv, 32'hC000_0000 + 32'(i));
         @(negedge clk);
         $display("alt %0d: g=%0b%0b v=%0b%0b", i, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid);
         chk("alt_m0_gnt",    100 + i, {31'd0, m0_gnt},    {31'd0, req_on & ~exp_g1});
         chk("alt_m1_gnt",    100 + i, {31'd0, m1_gnt},    {31'd0, req_on &  exp_g1});
         chk("alt_m0_rvalid", 100 + i, {31'd0, m0_rvalid}, {31'd0, exp_rv & ~exp_v1});
         chk("alt_m1_rvalid", 100 + i, {31'd0, m1_rvalid}, {31'd0, exp_rv &  exp_v1});
         @(posedge clk); #1;
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("alt_err", 107, {31'd0, err}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
